// File: rtl/screen_pkg.sv
// Shared definitions for the memory-mapped screen peripheral.
//   - register byte offsets inside the peripheral window
//   - bit positions inside the status register
//   - colour register width and type
package screen_pkg;

  localparam logic [63:0] OFFS_COLOR  = 64'd0;
  localparam logic [63:0] OFFS_STATUS = 64'd2;

  localparam int ST_DISP   = 0;
  localparam int ST_VBLANK = 1;
  localparam int ST_IRQ    = 2;

  localparam int COLOR_W = 12;

  typedef logic [COLOR_W-1:0] color_t;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider plus horizontal/vertical counters.
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   disp_enable  registered, high inside the visible area
//   hsync        registered, active-low horizontal sync
//   vsync        registered, active-low vertical sync
//   vblank       registered, high on lines at or beyond V_ACTIVE
//   frame_start  combinational, high on the pix_en where both counters wrap to 0,0
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clock,
  input  logic reset,
  output logic disp_enable,
  output logic hsync,
  output logic vsync,
  output logic vblank,
  output logic frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_SYNC_ON  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   H_SYNC_OFF = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_SYNC_ON  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   V_SYNC_OFF = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [H_W-1:0]   h_count;
  logic [V_W-1:0]   v_count;
  logic             pix_en;
  logic             h_wrap;
  logic             v_wrap;

  // Divider counts down; terminal count 0 is the pixel strobe. Starting at 0
  // out of reset makes the first frame begin on the very first clock.
  assign pix_en      = (div_cnt == '0);
  assign h_wrap      = (h_count == H_LAST);
  assign v_wrap      = (v_count == V_LAST);
  assign frame_start = pix_en && h_wrap && v_wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      h_count     <= '0;
      v_count     <= '0;
      // Reset values match what the counters at 0,0 would produce.
      disp_enable <= 1'b1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vblank      <= 1'b0;
    end else begin
      div_cnt <= pix_en ? DIV_RELOAD : div_cnt - 1'b1;
      if (pix_en) begin
        if (h_wrap) begin
          h_count <= '0;
          v_count <= v_wrap ? '0 : v_count + 1'b1;
        end else begin
          h_count <= h_count + 1'b1;
        end
      end
      disp_enable <= (h_count < H_ACT) && (v_count < V_ACT);
      hsync       <= !((h_count >= H_SYNC_ON) && (h_count < H_SYNC_OFF));
      vsync       <= !((v_count >= V_SYNC_ON) && (v_count < V_SYNC_OFF));
      vblank      <= (v_count >= V_ACT);
    end
  end

endmodule

// File: rtl/screen_mmio_responder.sv
// Memory-mapped screen peripheral: VGA timing plus a colour register and a
// pollable status register on the data-memory bus.
//   BASE_ADDR+0 : colour (write-only, 12-bit RGB 4:4:4, applied at next frame)
//   BASE_ADDR+2 : status (read-only, {irq_flag, vblank, disp_enable})
// Ports:
//   clock, reset            system clock, async active-low reset
//   sel, address            decoder hit and byte address
//   mem_write, data_in      store strobe and data
//   mem_read, data_out      load strobe and zero-latency load data
//   hsync, vsync            active-low syncs
//   red, green, blue        4-bit pixel colour, zero outside the visible area
//   irq                     frame interrupt (only with FRAME_IRQ_EN)
// Build option: define FRAME_IRQ_EN to add the sticky frame interrupt flag.
module screen_mmio_responder
  import screen_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000_0000_0000,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic [63:0] address,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
`ifdef FRAME_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic   disp_enable;
  logic   vblank;
  logic   frame_start;
  logic   color_wr;
  logic   status_rd;
  logic   irq_flag;
  logic   unused_data;
  color_t color_pending;
  color_t color_active;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clock      (clock),
    .reset      (reset),
    .disp_enable(disp_enable),
    .hsync      (hsync),
    .vsync      (vsync),
    .vblank     (vblank),
    .frame_start(frame_start)
  );

  assign color_wr    = sel && mem_write && (address == BASE_ADDR + OFFS_COLOR);
  assign status_rd   = sel && mem_read  && (address == BASE_ADDR + OFFS_STATUS);
  assign unused_data = ^data_in[63:COLOR_W];

  // Active colour only moves at the frame boundary so a frame never tears.
  // A write landing on the boundary clock is seen next frame, because the
  // boundary samples the pending value from before that write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      color_pending <= '0;
      color_active  <= '0;
    end else begin
      if (frame_start) color_active  <= color_pending;
      if (color_wr)    color_pending <= data_in[COLOR_W-1:0];
    end
  end

`ifdef FRAME_IRQ_EN
  // Sticky frame flag; a new frame outranks a clearing status read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           irq_flag <= 1'b0;
    else if (frame_start) irq_flag <= 1'b1;
    else if (status_rd)   irq_flag <= 1'b0;
  end
  assign irq = irq_flag;
`else
  assign irq_flag = 1'b0;
`endif

  assign {red, green, blue} = disp_enable ? color_active : '0;

  // Gated by reset so the bus sees zero while the block is held in reset.
  always_comb begin
    data_out = '0;
    if (status_rd && reset) begin
      data_out[ST_DISP]   = disp_enable;
      data_out[ST_VBLANK] = vblank;
      data_out[ST_IRQ]    = irq_flag;
    end
  end

endmodule

// File: tb/tb_screen_mmio_responder.sv
module tb_screen_mmio_responder;

  localparam logic [63:0] BASE = 64'h0200_0000_0000_0000;
  localparam int CDIV = 2;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int F  = HT * VT;
  localparam int FRAME_CLKS = F * CDIV;

  logic        clock;
  logic        reset;
  logic        sel;
  logic [63:0] address;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;
`ifdef FRAME_IRQ_EN
  logic        irq;
`endif

  screen_mmio_responder #(
    .BASE_ADDR(BASE), .CLK_DIV(CDIV),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clock(clock), .reset(reset), .sel(sel), .address(address),
    .mem_write(mem_write), .mem_read(mem_read), .data_in(data_in),
    .data_out(data_out), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
`ifdef FRAME_IRQ_EN
    , .irq(irq)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic [63:0] st;
    logic        irq;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          n;            // clock edges since reset release
  logic [11:0] pend_m, act_m;
  logic        irq_m;
  logic        in_reset;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at n=%0d: got=%h expected=%h", tag, n, got, exp);
    end
  endtask

  function automatic int pixcnt(input int k);
    return (k + CDIV - 1) / CDIV;
  endfunction

  function automatic bit next_is_boundary();
    return (pixcnt(n + 1) != pixcnt(n)) && ((pixcnt(n + 1) % F) == 0);
  endfunction

  task automatic push_expected();
    exp_t e;
    int k, p, h, v;
    logic disp, vbl;
    if (in_reset) begin
      e.hs = 1'b1; e.vs = 1'b1; e.rgb = '0; e.st = '0; e.irq = 1'b0;
    end else begin
      // Syncs/enable are registered: they reflect the raster position one edge ago.
      k = (n > 0) ? n - 1 : 0;
      p = pixcnt(k) % F;
      h = p % HT;
      v = p / HT;
      disp  = (h < HA) && (v < VA);
      vbl   = (v >= VA);
      e.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e.rgb = disp ? act_m : 12'h000;
      e.st  = '0;
      if (sel && mem_read && address == BASE + 64'd2) e.st = {61'b0, irq_m, vbl, disp};
      e.irq = irq_m;
    end
    sb.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    check_val("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("hsync", hsync, e.hs);
      check_val("vsync", vsync, e.vs);
      check_val("rgb", {red, green, blue}, e.rgb);
      check_val("status", data_out, e.st);
`ifdef FRAME_IRQ_EN
      check_val("irq", irq, e.irq);
`endif
    end
  endtask

  task automatic advance_model(input logic s, input logic [63:0] a, input logic w,
                               input logic r, input logic [63:0] d);
    bit bnd;
    bnd = next_is_boundary();
    if (bnd) act_m = pend_m;
`ifdef FRAME_IRQ_EN
    if (bnd) irq_m = 1'b1;
    else if (s && r && a == BASE + 64'd2) irq_m = 1'b0;
`endif
    if (s && w && a == BASE) pend_m = d[11:0];
    n++;
  endtask

  // One bus cycle: drive after the falling edge, check, then take the rising edge.
  task automatic step(input logic s, input logic [63:0] a, input logic w,
                      input logic r, input logic [63:0] d);
    sel = s; address = a; mem_write = w; mem_read = r; data_in = d;
    push_expected();
    #1;
    compare_outputs();
    @(posedge clock);
    advance_model(s, a, w, r, d);
    @(negedge clock);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic poll(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (i % 3 == 0) step(1'b1, BASE + 64'd2, 1'b0, 1'b1, 64'd0);
      else            step(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
    end
  endtask

  // Idle until the next rising edge is the frame boundary (bounded by a frame).
  task automatic run_to_boundary();
    for (int i = 0; i < FRAME_CLKS + 2; i++) begin
      if (next_is_boundary()) break;
      step(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    in_reset = 1'b1;
    sel = 1'b1; address = BASE + 64'd2; mem_read = 1'b1; mem_write = 1'b0; data_in = '0;
    push_expected();
    #1;
    compare_outputs();
    @(posedge clock);
    @(negedge clock);
    // A colour write while held in reset must not stick.
    sel = 1'b1; address = BASE; mem_write = 1'b1; mem_read = 1'b0; data_in = 64'hFFF;
    push_expected();
    #1;
    compare_outputs();
    @(posedge clock);
    #2;
    reset = 1'b1;
    in_reset = 1'b0;
    n = 0; pend_m = '0; act_m = '0; irq_m = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; address = '0; mem_write = 1'b0; mem_read = 1'b0; data_in = '0;
    in_reset = 1'b1; n = 0; pend_m = '0; act_m = '0; irq_m = 1'b0;

    do_reset();
    // First clock after release: visible pixel 0,0 -> status 0x1.
    step(1'b1, BASE + 64'd2, 1'b0, 1'b1, 64'd0);

    // Free run with polling, mid-frame colour write, then two frames to see it applied.
    poll(100);
    step(1'b1, BASE, 1'b1, 1'b0, 64'h0000_0000_0000_0ABC);
    poll(2 * FRAME_CLKS);

    // Ignored writes: status offset, unmapped offsets, deselected.
    step(1'b1, BASE + 64'd2, 1'b1, 1'b0, 64'h0000_0000_0000_FFFF);
    step(1'b1, BASE + 64'd1, 1'b1, 1'b0, 64'h0000_0000_0000_0111);
    step(1'b1, BASE + 64'd8, 1'b1, 1'b0, 64'h0000_0000_0000_0222);
    step(1'b0, BASE, 1'b1, 1'b0, 64'h0000_0000_0000_0333);

    // Write on the exact boundary clock: old value this frame, new one next frame.
    run_to_boundary();
    step(1'b1, BASE, 1'b1, 1'b0, 64'h0000_0000_0000_05A3);
    poll(FRAME_CLKS / 2);
    // Status read coincident with the boundary.
    run_to_boundary();
    step(1'b1, BASE + 64'd2, 1'b0, 1'b1, 64'd0);
    idle(3);
    step(1'b1, BASE + 64'd2, 1'b0, 1'b1, 64'd0);
    // Upper data bits ignored.
    step(1'b1, BASE, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0F5A);
    poll(FRAME_CLKS + 20);

    // Random bus traffic.
    for (int i = 0; i < 4 * FRAME_CLKS; i++) begin
      logic [63:0] a;
      case ($urandom_range(0, 4))
        0: a = BASE;
        1: a = BASE + 64'd2;
        2: a = BASE + 64'd1;
        3: a = BASE + 64'd8;
        default: a = 64'h0000_0000_0000_1000;
      endcase
      step(1'($urandom_range(0, 1)), a, ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    // Reset in the middle of a frame restarts the raster at 0,0.
    poll(57);
    do_reset();
    step(1'b1, BASE + 64'd2, 1'b0, 1'b1, 64'd0);
    step(1'b1, BASE, 1'b1, 1'b0, 64'h0000_0000_0000_0777);
    poll(FRAME_CLKS + 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish (vectors=%0d)", vectors);
    $fatal(1, "timeout");
  end

endmodule
